// File: rtl/truth_table_checker.sv
// Steps a 2-input gate through its four input vectors, waits SETTLE cycles per vector,
// and captures the gate output next to a reference output, reporting mismatches.
module truth_table_checker #(
    parameter int SETTLE = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       dut_s,
    input  logic       ref_s,
    output logic       x,
    output logic       y,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [1:0] first_err,
    output logic [3:0] table_dut,
    output logic [3:0] table_ref
);

    typedef enum logic [1:0] {IDLE, WAIT, SAMPLE, DONE} state_t;

    localparam logic [2:0] SETTLE_W = 3'(SETTLE);

    state_t     state_q, state_d;
    logic [1:0] idx_q, idx_d;
    logic [2:0] wait_q, wait_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       pass_q, pass_d;
    logic [2:0] err_q, err_d;
    logic [1:0] first_q, first_d;
    logic [3:0] tdut_q, tdut_d;
    logic [3:0] tref_q, tref_d;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        wait_d  = wait_q;
        busy_d  = busy_q;
        done_d  = done_q;
        err_d   = err_q;
        first_d = first_q;
        tdut_d  = tdut_q;
        tref_d  = tref_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    err_d   = 3'd0;
                    first_d = 2'd0;
                    tdut_d  = 4'd0;
                    tref_d  = 4'd0;
                    done_d  = 1'b0;
                    busy_d  = 1'b1;
                    idx_d   = 2'd0;
                    wait_d  = SETTLE_W;
                    state_d = (SETTLE == 0) ? SAMPLE : WAIT;
                end
            end
            WAIT: begin
                wait_d = wait_q - 3'd1;
                if (wait_q <= 3'd1) begin
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                tdut_d[idx_q] = dut_s;
                tref_d[idx_q] = ref_s;
                if (dut_s != ref_s) begin
                    if (err_q == 3'd0) begin
                        first_d = idx_q;
                    end
                    if (err_q < 3'd4) begin
                        err_d = err_q + 3'd1;
                    end
                end
                // The last vector keeps {x,y} at 11 so the final gate state stays observable.
                if (idx_q == 2'd3) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    idx_d   = idx_q + 2'd1;
                    wait_d  = SETTLE_W;
                    state_d = (SETTLE == 0) ? SAMPLE : WAIT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        pass_d = done_d && (err_d == 3'd0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= 2'd0;
            wait_q  <= 3'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= 3'd0;
            first_q <= 2'd0;
            tdut_q  <= 4'd0;
            tref_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            wait_q  <= wait_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            first_q <= first_d;
            tdut_q  <= tdut_d;
            tref_q  <= tref_d;
        end
    end

    assign x         = idx_q[1];
    assign y         = idx_q[0];
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_q;
    assign first_err = first_q;
    assign table_dut = tdut_q;
    assign table_ref = tref_q;

endmodule

// File: doc/truth_table_checker.md
TRUTH_TABLE_CHECKER -- requirements
Module: truth_table_checker

Interface
REQ-001 Parameter SETTLE, default 1: number of wait cycles between applying an input vector and sampling the outputs; legal range 0..7.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high; clears all state immediately and independently of clk.
REQ-004 start  input  1  run request; sampled on the rising edge of clk.
REQ-005 dut_s  input  1  output of the 2-input gate under test, e.g. the NAND-built OR.
REQ-006 ref_s  input  1  output of the behavioural control model for the same gate.
REQ-007 x  output  1  first gate input (MSB of the vector index).
REQ-008 y  output  1  second gate input (LSB of the vector index).
REQ-009 busy  output  1  high while a run is in progress.
REQ-010 done  output  1  high from run completion until the next accepted start or reset.
REQ-011 pass  output  1  equals done AND (err_count == 0).
REQ-012 err_count  output  3  number of mismatching vectors in the last run, 0..4.
REQ-013 first_err  output  2  vector index of the first mismatch; valid only when err_count != 0.
REQ-014 table_dut  output  4  captured dut_s values; bit i corresponds to vector {x,y} = i.
REQ-015 table_ref  output  4  captured ref_s values, with the same indexing as table_dut.

Function
REQ-016 FSM states: IDLE, WAIT, SAMPLE, DONE. State encoding is free; state is not visible as a port.
REQ-017 IDLE or DONE, start=1 at an edge: that edge clears err_count, first_err, table_dut and table_ref, clears done, sets idx=0 and {x,y}=00, loads the wait counter with SETTLE, and moves the FSM to WAIT. If SETTLE=0, the FSM moves directly to SAMPLE.
REQ-018 WAIT: the wait counter decrements on each edge; on the edge where the counter reaches 0, the FSM moves to SAMPLE. The FSM spends exactly SETTLE cycles in WAIT.
REQ-019 SAMPLE takes one cycle. At its edge: table_dut[idx] <= dut_s and table_ref[idx] <= ref_s. If dut_s != ref_s, err_count increments; if err_count was 0 at that edge, first_err <= idx.
REQ-020 SAMPLE with idx < 3: idx increments, {x,y} <= new idx in the same edge, the wait counter reloads, and the FSM returns to WAIT, or stays in SAMPLE when SETTLE=0.
REQ-021 SAMPLE with idx = 3: the FSM moves to DONE, done <= 1, and {x,y} holds at 11.
REQ-022 busy = 1 in WAIT and SAMPLE, 0 in IDLE and DONE.
REQ-023 Latency: done rises exactly 4*(SETTLE+1) rising edges after the edge that accepted start.
REQ-024 start while busy is ignored and has no effect on the run in progress.
REQ-025 Results (tables, err_count, first_err, pass) stay stable in DONE until the next accepted start.
REQ-026 A start held high continuously in DONE restarts on the first edge in DONE; done is then high for one cycle.
REQ-027 err_count never wraps; at most 4 vectors are counted per run.
REQ-028 dut_s and ref_s are used only at SAMPLE edges; their values at all other times are don't-care.
REQ-029 x and y are driven directly from registers, never combinationally from inputs.

Reset
REQ-030 reset=1 forces, asynchronously: state=IDLE, x=0, y=0, busy=0, done=0, pass=0, err_count=0, first_err=0, table_dut=0000, table_ref=0000, idx=0, wait counter=0.
REQ-031 Reset asserted mid-run aborts the run with no partial results retained; after release the block waits in IDLE for start.
REQ-032 start is ignored while reset=1; the first start can be accepted on the first rising edge after reset deasserts.

Verification
REQ-033 SETTLE=1, dut_s=ref_s=x|y, one-cycle start -> x,y sequence 00,01,10,11 with each vector held 2 cycles; done rises 8 edges after start; table_dut=table_ref=1110; err_count=0; pass=1.
REQ-034 dut_s tied 0, ref_s=x|y -> table_dut=0000, table_ref=1110, err_count=3, first_err=01, pass=0, done=1.
REQ-035 dut_s=x&y, ref_s=x|y -> table_dut=1000, err_count=2, first_err=01, pass=0.
REQ-036 start pulsed at the 3rd busy cycle, then reset pulsed during vector 10 -> the mid-run start causes no restart; all outputs are 0 immediately on reset; a fresh start after release completes normally with pass=1.
REQ-037 SETTLE=0, start held high for 6 cycles -> done rises 4 edges after the first accepted start; the block restarts from DONE with tables cleared; the second run's results equal the first run's.
REQ-038 SETTLE=7, matching gates -> done rises exactly 32 edges after start; busy is high for exactly those 32 cycles.
